// File: rtl/pong_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pong_pkg: playfield geometry, FSM state codes and the paddle step    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pong_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int PADDLE_W = 10;
  localparam int PADDLE_H = 80;
  localparam int P1_X     = 20;
  localparam int P2_X     = 610;
  localparam int BALL_SZ  = 8;
  localparam int GOAL_H   = 160;
  localparam int STEP     = 4;
  localparam int DEB_CYC  = 16;

  localparam logic [3:0] RST_CYC = 4'd8;

  localparam logic [9:0] P1_LEFT   = 10'(P1_X);
  localparam logic [9:0] P1_RIGHT  = 10'(P1_X + PADDLE_W - 1);
  localparam logic [9:0] P2_LEFT   = 10'(P2_X);
  localparam logic [9:0] P2_RIGHT  = 10'(P2_X + PADDLE_W - 1);
  localparam logic [9:0] BALL_XLIM = 10'(SCREEN_W - BALL_SZ);
  localparam logic [8:0] BALL_YLIM = 9'(SCREEN_H - BALL_SZ);
  localparam logic [9:0] BALL_XINIT = 10'(SCREEN_W / 2 - BALL_SZ / 2);
  localparam logic [8:0] BALL_YINIT = 9'(SCREEN_H / 2 - BALL_SZ / 2);
  localparam logic [8:0] SEG_TOP   = 9'((SCREEN_H - GOAL_H) / 2);
  localparam logic [8:0] SEG_BOT   = 9'((SCREEN_H - GOAL_H) / 2 + GOAL_H - 1);

  localparam logic [8:0] PADDLE_SPAN    = 9'(PADDLE_H - 1);
  localparam logic [8:0] PADDLE_TOP_MAX = 9'(SCREEN_H - PADDLE_H);
  localparam logic [8:0] PADDLE_CENTRE  = 9'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [8:0] STEP_Y         = 9'(STEP);

  localparam logic [1:0] ST_PLAY  = 2'd0;
  localparam logic [1:0] ST_OVER  = 2'd1;
  localparam logic [1:0] ST_SERVE = 2'd2;

  localparam logic [1:0] WIN_NONE = 2'b00;

  // Saturating paddle move; the 10-bit sum keeps a downward step from wrapping.
  function automatic logic [8:0] paddle_next(input logic [8:0] top,
                                             input logic up, input logic dn);
    logic [9:0] sum;
    sum = {1'b0, top} + {1'b0, STEP_Y};
    if (up && !dn)
      return (top < STEP_Y) ? 9'd0 : top - STEP_Y;
    else if (dn && !up)
      return (sum > {1'b0, PADDLE_TOP_MAX}) ? PADDLE_TOP_MAX : sum[8:0];
    else
      return top;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pong_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pong_debounce: 2-flop synchronizer plus stable-count debouncer       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pong_debounce #(
  parameter int DEB_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_stable
);

  localparam int CW = (DEB_CYC > 2) ? $clog2(DEB_CYC) : 1;
  localparam logic [CW-1:0] C_CNT_LAST = CW'(DEB_CYC - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == C_CNT_LAST) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_stable = r_stable;

endmodule
`default_nettype wire

// File: rtl/pong_io_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pong_io_ctrl: button conditioning, frame tick, paddles, geometry     |
// | bounds, display latch and game-over/serve sequencing. Rev 1.0        |
// +----------------------------------------------------------------------+
module pong_io_ctrl
  import pong_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       screenEnd,
  input  logic       p1_up,
  input  logic       p1_down,
  input  logic       p2_up,
  input  logic       p2_down,
  input  logic [1:0] winner,
  input  logic [9:0] ball_x,
  input  logic [8:0] ball_y,
  output logic       posEdgeScreenEnd,
  output logic [9:0] p1_leftBound,
  output logic [9:0] p1_rightBound,
  output logic [9:0] p2_leftBound,
  output logic [9:0] p2_rightBound,
  output logic [8:0] p1_topBound,
  output logic [8:0] p1_bottomBound,
  output logic [8:0] p2_topBound,
  output logic [8:0] p2_bottomBound,
  output logic [9:0] ball_xlim,
  output logic [8:0] ball_ylim,
  output logic [9:0] ball_xinit,
  output logic [8:0] ball_yinit,
  output logic [8:0] segLeft_topBound,
  output logic [8:0] segLeft_bottomBound,
  output logic [8:0] segRight_topBound,
  output logic [8:0] segRight_bottomBound,
  output logic [9:0] disp_x,
  output logic [8:0] disp_y,
  output logic [1:0] winner_latched,
  output logic       cpu_reset
);

  logic w_p1_up, w_p1_down, w_p2_up, w_p2_down;

  pong_debounce #(.DEB_CYC(DEB_CYC)) u_deb_p1_up   (.clk(clock), .rst(reset), .i_raw(p1_up),   .o_stable(w_p1_up));
  pong_debounce #(.DEB_CYC(DEB_CYC)) u_deb_p1_down (.clk(clock), .rst(reset), .i_raw(p1_down), .o_stable(w_p1_down));
  pong_debounce #(.DEB_CYC(DEB_CYC)) u_deb_p2_up   (.clk(clock), .rst(reset), .i_raw(p2_up),   .o_stable(w_p2_up));
  pong_debounce #(.DEB_CYC(DEB_CYC)) u_deb_p2_down (.clk(clock), .rst(reset), .i_raw(p2_down), .o_stable(w_p2_down));

  logic r_se_s1, r_se_s2, r_se_prev, r_tick;

  // Registered edge detect: the tick lands three clocks after screenEnd rises.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_se_s1   <= 1'b0;
      r_se_s2   <= 1'b0;
      r_se_prev <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_se_s1   <= screenEnd;
      r_se_s2   <= r_se_s1;
      r_se_prev <= r_se_s2;
      r_tick    <= r_se_s2 & ~r_se_prev;
    end
  end

  logic [9:0] r_disp_x;
  logic [8:0] r_disp_y;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_disp_x <= BALL_XINIT;
      r_disp_y <= BALL_YINIT;
    end else if (r_tick) begin
      r_disp_x <= ball_x;
      r_disp_y <= ball_y;
    end
  end

  logic [1:0] r_state;
  logic [3:0] r_serve_cnt;
  logic [8:0] r_p1_top;
  logic [8:0] r_p2_top;
  logic [1:0] r_winner;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_PLAY;
      r_serve_cnt <= '0;
      r_p1_top    <= PADDLE_CENTRE;
      r_p2_top    <= PADDLE_CENTRE;
      r_winner    <= WIN_NONE;
    end else begin
      case (r_state)
        ST_PLAY: begin
          if (r_tick) begin
            r_p1_top <= paddle_next(r_p1_top, w_p1_up, w_p1_down);
            r_p2_top <= paddle_next(r_p2_top, w_p2_up, w_p2_down);
            if (winner != WIN_NONE) begin
              r_winner <= winner;
              r_state  <= ST_OVER;
            end
          end
        end
        ST_OVER: begin
          if (w_p1_up && w_p2_up) begin
            r_state     <= ST_SERVE;
            r_serve_cnt <= '0;
          end
        end
        ST_SERVE: begin
          r_p1_top <= PADDLE_CENTRE;
          r_p2_top <= PADDLE_CENTRE;
          if (r_serve_cnt == RST_CYC - 4'd1) begin
            r_state     <= ST_PLAY;
            r_winner    <= WIN_NONE;
            r_serve_cnt <= '0;
          end else begin
            r_serve_cnt <= r_serve_cnt + 4'd1;
          end
        end
        default: r_state <= ST_PLAY;
      endcase
    end
  end

  assign posEdgeScreenEnd     = r_tick;
  assign cpu_reset            = (r_state == ST_SERVE);
  assign winner_latched       = r_winner;
  assign disp_x               = r_disp_x;
  assign disp_y               = r_disp_y;
  assign p1_topBound          = r_p1_top;
  assign p1_bottomBound       = r_p1_top + PADDLE_SPAN;
  assign p2_topBound          = r_p2_top;
  assign p2_bottomBound       = r_p2_top + PADDLE_SPAN;
  assign p1_leftBound         = P1_LEFT;
  assign p1_rightBound        = P1_RIGHT;
  assign p2_leftBound         = P2_LEFT;
  assign p2_rightBound        = P2_RIGHT;
  assign ball_xlim            = BALL_XLIM;
  assign ball_ylim            = BALL_YLIM;
  assign ball_xinit           = BALL_XINIT;
  assign ball_yinit           = BALL_YINIT;
  assign segLeft_topBound     = SEG_TOP;
  assign segLeft_bottomBound  = SEG_BOT;
  assign segRight_topBound    = SEG_TOP;
  assign segRight_bottomBound = SEG_BOT;

endmodule
`default_nettype wire

// File: tb/tb_pong_io_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pong_io_ctrl: directed table-driven bench for pong_io_ctrl        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pong_io_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       screenEnd;
  logic       p1_up, p1_down, p2_up, p2_down;
  logic [1:0] winner;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic       posEdgeScreenEnd;
  logic [9:0] p1_leftBound, p1_rightBound, p2_leftBound, p2_rightBound;
  logic [8:0] p1_topBound, p1_bottomBound, p2_topBound, p2_bottomBound;
  logic [9:0] ball_xlim, ball_xinit;
  logic [8:0] ball_ylim, ball_yinit;
  logic [8:0] segLeft_topBound, segLeft_bottomBound, segRight_topBound, segRight_bottomBound;
  logic [9:0] disp_x;
  logic [8:0] disp_y;
  logic [1:0] winner_latched;
  logic       cpu_reset;

  always #5 clock = ~clock;

  pong_io_ctrl dut (
    .clock(clock), .reset(reset), .screenEnd(screenEnd),
    .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
    .winner(winner), .ball_x(ball_x), .ball_y(ball_y),
    .posEdgeScreenEnd(posEdgeScreenEnd),
    .p1_leftBound(p1_leftBound), .p1_rightBound(p1_rightBound),
    .p2_leftBound(p2_leftBound), .p2_rightBound(p2_rightBound),
    .p1_topBound(p1_topBound), .p1_bottomBound(p1_bottomBound),
    .p2_topBound(p2_topBound), .p2_bottomBound(p2_bottomBound),
    .ball_xlim(ball_xlim), .ball_ylim(ball_ylim),
    .ball_xinit(ball_xinit), .ball_yinit(ball_yinit),
    .segLeft_topBound(segLeft_topBound), .segLeft_bottomBound(segLeft_bottomBound),
    .segRight_topBound(segRight_topBound), .segRight_bottomBound(segRight_bottomBound),
    .disp_x(disp_x), .disp_y(disp_y),
    .winner_latched(winner_latched), .cpu_reset(cpu_reset)
  );

  typedef struct {
    int   player;
    logic up;
    logic dn;
    int   frames;
    int   exp_top;
  } vec_t;

  vec_t tbl[6];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // 10 cycles high, 10 low; optionally drops p2_up at cycle rel_at.
  task automatic do_frame(input int rel_at);
    int cnt;
    int pos;
    cnt = 0;
    pos = -1;
    screenEnd = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock);
      #1;
      if (i == 10) screenEnd = 1'b0;
      if (i == rel_at) p2_up = 1'b0;
      if (posEdgeScreenEnd) begin
        cnt++;
        if (pos < 0) pos = i;
      end
    end
    chk("tick_width", cnt, 1);
    chk("tick_delay", pos, 3);
  endtask

  function automatic int model(input int t, input logic up, input logic dn);
    if (up && !dn) return (t < 4) ? 0 : t - 4;
    if (dn && !up) return (t + 4 > 400) ? 400 : t + 4;
    return t;
  endfunction

  initial begin
    int m1;
    int m2;
    int hi_cnt;
    int seen;

    tbl[0] = '{1, 1'b1, 1'b0, 60, 0};
    tbl[1] = '{1, 1'b0, 1'b1, 10, 40};
    tbl[2] = '{2, 1'b0, 1'b1, 100, 400};
    tbl[3] = '{2, 1'b1, 1'b1, 5, 400};
    tbl[4] = '{2, 1'b1, 1'b0, 3, 388};
    tbl[5] = '{1, 1'b0, 1'b0, 2, 40};

    reset = 1'b1;
    screenEnd = 1'b0;
    {p1_up, p1_down, p2_up, p2_down} = 4'b0;
    winner = 2'b00;
    ball_x = 10'd0;
    ball_y = 9'd0;
    cyc(3);
    chk("rst_p1_top", p1_topBound, 200);
    chk("rst_p1_bot", p1_bottomBound, 279);
    chk("rst_p1_left", p1_leftBound, 20);
    chk("rst_p1_right", p1_rightBound, 29);
    chk("rst_p2_left", p2_leftBound, 610);
    chk("rst_p2_right", p2_rightBound, 619);
    chk("rst_p2_top", p2_topBound, 200);
    chk("rst_xlim", ball_xlim, 632);
    chk("rst_ylim", ball_ylim, 472);
    chk("rst_xinit", ball_xinit, 316);
    chk("rst_yinit", ball_yinit, 236);
    chk("rst_segL_top", segLeft_topBound, 160);
    chk("rst_segL_bot", segLeft_bottomBound, 319);
    chk("rst_segR_top", segRight_topBound, 160);
    chk("rst_segR_bot", segRight_bottomBound, 319);
    chk("rst_disp_x", disp_x, 316);
    chk("rst_disp_y", disp_y, 236);
    chk("rst_cpu_reset", cpu_reset, 0);
    chk("rst_winner", winner_latched, 0);
    chk("rst_tick", posEdgeScreenEnd, 0);
    reset = 1'b0;
    cyc(2);

    m1 = 200;
    m2 = 200;
    for (int r = 0; r < 6; r++) begin
      p1_up   = (tbl[r].player == 1) && tbl[r].up;
      p1_down = (tbl[r].player == 1) && tbl[r].dn;
      p2_up   = (tbl[r].player == 2) && tbl[r].up;
      p2_down = (tbl[r].player == 2) && tbl[r].dn;
      cyc(25);
      for (int f = 0; f < tbl[r].frames; f++) begin
        do_frame(0);
        if (tbl[r].player == 1) begin
          m1 = model(m1, tbl[r].up, tbl[r].dn);
          chk("p1_top", p1_topBound, m1);
          chk("p1_bot", p1_bottomBound, m1 + 79);
        end else begin
          m2 = model(m2, tbl[r].up, tbl[r].dn);
          chk("p2_top", p2_topBound, m2);
          chk("p2_bot", p2_bottomBound, m2 + 79);
        end
      end
      chk("row_final_top", (tbl[r].player == 1) ? int'(p1_topBound) : int'(p2_topBound), tbl[r].exp_top);
    end
    {p1_up, p1_down, p2_up, p2_down} = 4'b0;
    cyc(25);

    p2_up = 1'b1;
    cyc(5);
    p2_up = 1'b0;
    do_frame(0);
    chk("glitch_no_move", p2_topBound, 388);

    p2_up = 1'b1;
    cyc(20);
    do_frame(10);
    chk("press_one_move", p2_topBound, 384);
    cyc(30);
    do_frame(0);
    chk("press_no_repeat", p2_topBound, 384);

    ball_x = 10'd100;
    ball_y = 9'd50;
    do_frame(0);
    chk("disp_x_100", disp_x, 100);
    chk("disp_y_50", disp_y, 50);
    ball_x = 10'd101;
    cyc(5);
    chk("disp_x_hold", disp_x, 100);
    do_frame(0);
    chk("disp_x_101", disp_x, 101);

    winner = 2'b10;
    do_frame(0);
    chk("win_latched", winner_latched, 2);
    winner = 2'b00;
    p1_down = 1'b1;
    cyc(25);
    do_frame(0);
    do_frame(0);
    chk("over_frozen_p1", p1_topBound, 40);
    chk("over_hold_win", winner_latched, 2);
    p1_down = 1'b0;
    p1_up = 1'b1;
    p2_up = 1'b1;
    hi_cnt = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clock);
      #1;
      if (cpu_reset) hi_cnt++;
    end
    chk("cpu_reset_len", hi_cnt, 8);
    chk("serve_p1_top", p1_topBound, 200);
    chk("serve_p2_top", p2_topBound, 200);
    chk("serve_win_clr", winner_latched, 0);
    do_frame(0);
    chk("play_p1_move", p1_topBound, 196);
    chk("play_p2_move", p2_topBound, 196);

    p1_up = 1'b0;
    p2_up = 1'b0;
    cyc(25);
    winner = 2'b01;
    cyc(3);
    winner = 2'b00;
    do_frame(0);
    chk("win_between_ticks", winner_latched, 0);

    winner = 2'b01;
    do_frame(0);
    chk("win_p1_latched", winner_latched, 1);
    winner = 2'b00;
    p1_up = 1'b1;
    p2_up = 1'b1;
    seen = 0;
    for (int i = 0; i < 60 && seen == 0; i++) begin
      @(posedge clock);
      #1;
      if (cpu_reset) seen = 1;
    end
    chk("serve_started", seen, 1);
    cyc(2);
    chk("serve_mid", cpu_reset, 1);
    reset = 1'b1;
    #1;
    chk("abort_cpu_reset", cpu_reset, 0);
    chk("abort_winner", winner_latched, 0);
    p1_up = 1'b0;
    p2_up = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(25);
    chk("abort_p1_top", p1_topBound, 200);
    chk("abort_cpu_low", cpu_reset, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
